sirv_icb2to1_arb: RTL and testbench
===================================

Name: sirv_icb2to1_arb

Overview:
- Arbitrates two ICB masters (i0, i1) onto one shared ICB slave port (o).
- Sits upstream of a 1-to-2 splitter bus or a single peripheral, so two requesters (e.g. core LSU and debug/DMA) can share one fabric path.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the master that issued the command.
- Supports round-robin or fixed-priority arbitration, grant hold under back-pressure, and lock sequences.

Parameters:
- AW, 32, address width.
- DW, 32, data width (wmask is DW/8).
- OUTS_NUM, 2, maximum outstanding commands (1..8); this is also the ID FIFO depth.
- RR_EN, 1: 1 = round-robin; 0 = fixed priority with i0 highest.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- iN_icb_cmd_valid  in  1  command valid from master N (N = 0,1; applies to all iN_* lines)
- iN_icb_cmd_ready  out  1  command accepted
- iN_icb_cmd_addr  in  AW  address
- iN_icb_cmd_read  in  1  1 = read
- iN_icb_cmd_wdata  in  DW  write data
- iN_icb_cmd_wmask  in  DW/8  byte mask
- iN_icb_cmd_size  in  2  access size
- iN_icb_cmd_lock  in  1  lock request
- iN_icb_rsp_valid  out  1  response valid
- iN_icb_rsp_ready  in  1  response accept
- iN_icb_rsp_err  out  1  response error
- iN_icb_rsp_rdata  out  DW  read data
- o_icb_cmd_valid/ready/addr/read/wdata/wmask/size/lock  out/in/out...  same widths  shared command channel
- o_icb_rsp_valid  in  1  shared response valid
- o_icb_rsp_ready  out  1  shared response ready
- o_icb_rsp_err  in  1  shared response error
- o_icb_rsp_rdata  in  DW  shared response data

Behaviour:
- Clock and reset (already decided): single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - rr_ptr = 0, so i0 is preferred first.
  - hold_vld = 0, lock_vld = 0.
  - outs_cnt = 0; FIFO rd_ptr = wr_ptr = 0 (empty).
  - All iN_cmd_ready, iN_rsp_valid, o_cmd_valid and o_rsp_ready = 0.
- Grant selection, in priority order:
  - If hold_vld or lock_vld: keep the registered grant (gnt_q).
  - Else if RR_EN: the requester at rr_ptr wins if valid, otherwise the other one.
  - Else (RR_EN = 0): i0 wins if valid.
- Full gating:
  - outs_full = (outs_cnt == OUTS_NUM).
  - o_cmd_valid = selected iN_cmd_valid & ~outs_full.
  - Payload is muxed from the granted master with zero added latency.
- Ready: iN_cmd_ready = (gnt == N) & o_cmd_ready & ~outs_full; the non-granted master's ready is 0.
- Hold:
  - If o_cmd_valid & ~o_cmd_ready: hold_vld <= 1 and gnt_q <= gnt.
  - hold_vld clears on handshake, so the grant and payload source never change while the output is stalled.
- Round-robin update: on each cmd handshake, rr_ptr <= ~gnt (the other master gets priority next).
- Lock:
  - A handshake with lock = 1 sets lock_vld = 1 and gnt_q = gnt.
  - A handshake from the same master with lock = 0 clears lock_vld.
  - While lock_vld is set, the other master is fully starved.
- ID FIFO:
  - Each cmd handshake pushes gnt (1 bit) at wr_ptr.
  - Each rsp handshake (o_rsp_valid & o_rsp_ready) pops at rd_ptr.
  - Pointers wrap modulo OUTS_NUM.
  - outs_cnt: +1 on push only, -1 on pop only, unchanged when both occur in the same cycle.
- Response routing:
  - head = FIFO[rd_ptr].
  - iN_rsp_valid = o_rsp_valid & (outs_cnt != 0) & (head == N).
  - o_rsp_ready = (outs_cnt != 0) & ready of the head master.
  - err and rdata are broadcast to both masters.
- Zero-cycle responses (response in the same cycle as its command) are not supported. With the FIFO empty, o_rsp_ready = 0 and o_rsp_valid is ignored.
- Simultaneous push and pop when full: a push is impossible because outs_full blocks the command. A pop in that cycle frees a slot usable from the next cycle.
- Reset mid-transaction: all state clears immediately, and outstanding responses arriving after reset are not routed.

Test Plan:
- Both masters valid every cycle, RR_EN=1, o_cmd_ready=1, 1-cycle slave: grants alternate i0,i1,i0,i1; responses return to i0,i1,i0,i1 in order, with rdata matching the addresses.
- RR_EN=0, both valid: i0 is granted 4 consecutive times and i1_cmd_ready stays 0 until i0 deasserts.
- o_cmd_ready held 0 for 3 cycles while i1 requests, then i0 raises valid: grant stays on i1 (addr stable at 0x1000) until the handshake; i0 is granted next.
- OUTS_NUM=2, slave delays responses: after 2 accepted commands o_cmd_valid=0 and both readys=0; one response pops and a third command is accepted the following cycle; outs_cnt never exceeds 2.
- i0 issues lock=1 to 0x2000 then lock=0 to 0x2004 while i1 requests continuously: i1 is starved until the unlock handshake and granted the next cycle.
- Assert rst_n low with 2 commands outstanding: all outputs drop to 0 asynchronously, outs_cnt=0, and after release the first grant goes to i0.

Source files
------------

// File: rtl/sirv_icb2to1_arb.sv
// Two-master to one-slave ICB arbiter. Round-robin or fixed priority, with grant hold
// and lock. An in-order ID FIFO routes each response back to the master that issued it.
module sirv_icb2to1_arb #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned OUTS_NUM = 2,
    parameter int unsigned RR_EN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i0_icb_cmd_valid,
    output logic              i0_icb_cmd_ready,
    input  logic [AW-1:0]     i0_icb_cmd_addr,
    input  logic              i0_icb_cmd_read,
    input  logic [DW-1:0]     i0_icb_cmd_wdata,
    input  logic [DW/8-1:0]   i0_icb_cmd_wmask,
    input  logic [1:0]        i0_icb_cmd_size,
    input  logic              i0_icb_cmd_lock,
    output logic              i0_icb_rsp_valid,
    input  logic              i0_icb_rsp_ready,
    output logic              i0_icb_rsp_err,
    output logic [DW-1:0]     i0_icb_rsp_rdata,

    input  logic              i1_icb_cmd_valid,
    output logic              i1_icb_cmd_ready,
    input  logic [AW-1:0]     i1_icb_cmd_addr,
    input  logic              i1_icb_cmd_read,
    input  logic [DW-1:0]     i1_icb_cmd_wdata,
    input  logic [DW/8-1:0]   i1_icb_cmd_wmask,
    input  logic [1:0]        i1_icb_cmd_size,
    input  logic              i1_icb_cmd_lock,
    output logic              i1_icb_rsp_valid,
    input  logic              i1_icb_rsp_ready,
    output logic              i1_icb_rsp_err,
    output logic [DW-1:0]     i1_icb_rsp_rdata,

    output logic              o_icb_cmd_valid,
    input  logic              o_icb_cmd_ready,
    output logic [AW-1:0]     o_icb_cmd_addr,
    output logic              o_icb_cmd_read,
    output logic [DW-1:0]     o_icb_cmd_wdata,
    output logic [DW/8-1:0]   o_icb_cmd_wmask,
    output logic [1:0]        o_icb_cmd_size,
    output logic              o_icb_cmd_lock,
    input  logic              o_icb_rsp_valid,
    output logic              o_icb_rsp_ready,
    input  logic              o_icb_rsp_err,
    input  logic [DW-1:0]     o_icb_rsp_rdata
);

    localparam int unsigned PTR_W = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(OUTS_NUM + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTS_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTS_NUM);

    logic                rr_ptr_q, rr_ptr_d;
    logic                hold_vld_q, hold_vld_d;
    logic                lock_vld_q, lock_vld_d;
    logic                gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OUTS_NUM-1:0] fifo_q, fifo_d;

    logic gnt_c, sel_valid_c, sel_lock_c, outs_full_c, outs_empty_c;
    logic cmd_vld_c, cmd_hs_c, head_c, head_rdy_c, rsp_hs_c;

    // Grant: a stalled or locked grant is frozen; otherwise RR pointer or fixed priority
    always_comb begin
        if (hold_vld_q || lock_vld_q) begin
            gnt_c = gnt_q;
        end else if (RR_EN != 0) begin
            gnt_c = rr_ptr_q ? i1_icb_cmd_valid : ~i0_icb_cmd_valid;
        end else begin
            gnt_c = ~i0_icb_cmd_valid;
        end
    end

    assign sel_valid_c  = gnt_c ? i1_icb_cmd_valid : i0_icb_cmd_valid;
    assign sel_lock_c   = gnt_c ? i1_icb_cmd_lock  : i0_icb_cmd_lock;
    assign outs_full_c  = (cnt_q == CNT_FULL);
    assign outs_empty_c = (cnt_q == '0);
    assign cmd_vld_c    = sel_valid_c & ~outs_full_c;
    assign cmd_hs_c     = cmd_vld_c & o_icb_cmd_ready;

    assign head_c     = fifo_q[rd_ptr_q];
    assign head_rdy_c = head_c ? i1_icb_rsp_ready : i0_icb_rsp_ready;
    assign rsp_hs_c   = o_icb_rsp_valid & ~outs_empty_c & head_rdy_c;

    // Handshake outputs are forced low while reset is asserted
    assign o_icb_cmd_valid  = rst_n & cmd_vld_c;
    assign i0_icb_cmd_ready = rst_n & ~gnt_c & o_icb_cmd_ready & ~outs_full_c;
    assign i1_icb_cmd_ready = rst_n &  gnt_c & o_icb_cmd_ready & ~outs_full_c;
    assign o_icb_cmd_addr   = gnt_c ? i1_icb_cmd_addr  : i0_icb_cmd_addr;
    assign o_icb_cmd_read   = gnt_c ? i1_icb_cmd_read  : i0_icb_cmd_read;
    assign o_icb_cmd_wdata  = gnt_c ? i1_icb_cmd_wdata : i0_icb_cmd_wdata;
    assign o_icb_cmd_wmask  = gnt_c ? i1_icb_cmd_wmask : i0_icb_cmd_wmask;
    assign o_icb_cmd_size   = gnt_c ? i1_icb_cmd_size  : i0_icb_cmd_size;
    assign o_icb_cmd_lock   = sel_lock_c;

    assign o_icb_rsp_ready  = rst_n & ~outs_empty_c & head_rdy_c;
    assign i0_icb_rsp_valid = rst_n & o_icb_rsp_valid & ~outs_empty_c & ~head_c;
    assign i1_icb_rsp_valid = rst_n & o_icb_rsp_valid & ~outs_empty_c &  head_c;
    assign i0_icb_rsp_err   = o_icb_rsp_err;
    assign i1_icb_rsp_err   = o_icb_rsp_err;
    assign i0_icb_rsp_rdata = o_icb_rsp_rdata;
    assign i1_icb_rsp_rdata = o_icb_rsp_rdata;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        hold_vld_d = hold_vld_q;
        lock_vld_d = lock_vld_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_d     = fifo_q;

        if (cmd_hs_c) begin
            rr_ptr_d         = ~gnt_c;
            hold_vld_d       = 1'b0;
            fifo_d[wr_ptr_q] = gnt_c;
            wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (sel_lock_c) begin
                lock_vld_d = 1'b1;
                gnt_d      = gnt_c;
            end else begin
                lock_vld_d = 1'b0;
            end
        end else if (cmd_vld_c) begin
            hold_vld_d = 1'b1;
            gnt_d      = gnt_c;
        end

        if (rsp_hs_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({cmd_hs_c, rsp_hs_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= 1'b0;
            hold_vld_q <= 1'b0;
            lock_vld_q <= 1'b0;
            gnt_q      <= 1'b0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            hold_vld_q <= hold_vld_d;
            lock_vld_q <= lock_vld_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_q     <= fifo_d;
        end
    end

endmodule

// File: tb/tb_sirv_icb2to1_arb.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus; a small
// slave answers the selected instance one cycle after each command, or is driven by hand.
module tb_sirv_icb2to1_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        i0_valid = 1'b0, i1_valid = 1'b0;
    logic [31:0] i0_addr = '0, i1_addr = '0;
    logic        i0_lock = 1'b0, i1_lock = 1'b0;
    logic        i0_rsp_ready = 1'b1, i1_rsp_ready = 1'b1;
    logic        o_cmd_ready = 1'b0;
    logic        auto_rsp = 1'b0, sel_fp = 1'b0;
    logic        man_rsp_valid = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        s_vld_q = 1'b0;
    logic [31:0] s_rdata_q = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;

    logic        rr_i0_rdy, rr_i1_rdy, rr_i0_rv, rr_i1_rv, rr_i0_err, rr_i1_err;
    logic [31:0] rr_i0_rd, rr_i1_rd, rr_addr, rr_wdata;
    logic        rr_ov, rr_read, rr_lock, rr_ordy;
    logic [3:0]  rr_wmask;
    logic [1:0]  rr_size;
    logic        fp_i0_rdy, fp_i1_rdy, fp_i0_rv, fp_i1_rv, fp_i0_err, fp_i1_err;
    logic [31:0] fp_i0_rd, fp_i1_rd, fp_addr, fp_wdata;
    logic        fp_ov, fp_read, fp_lock, fp_ordy;
    logic [3:0]  fp_wmask;
    logic [1:0]  fp_size;

    int total = 0;
    int passed = 0;
    int fails = 0;

    sirv_icb2to1_arb #(.AW(32), .DW(32), .OUTS_NUM(2), .RR_EN(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .i0_icb_cmd_valid(i0_valid), .i0_icb_cmd_ready(rr_i0_rdy), .i0_icb_cmd_addr(i0_addr),
        .i0_icb_cmd_read(1'b1), .i0_icb_cmd_wdata(32'h0), .i0_icb_cmd_wmask(4'hF),
        .i0_icb_cmd_size(2'd2), .i0_icb_cmd_lock(i0_lock),
        .i0_icb_rsp_valid(rr_i0_rv), .i0_icb_rsp_ready(i0_rsp_ready),
        .i0_icb_rsp_err(rr_i0_err), .i0_icb_rsp_rdata(rr_i0_rd),
        .i1_icb_cmd_valid(i1_valid), .i1_icb_cmd_ready(rr_i1_rdy), .i1_icb_cmd_addr(i1_addr),
        .i1_icb_cmd_read(1'b1), .i1_icb_cmd_wdata(32'h0), .i1_icb_cmd_wmask(4'hF),
        .i1_icb_cmd_size(2'd2), .i1_icb_cmd_lock(i1_lock),
        .i1_icb_rsp_valid(rr_i1_rv), .i1_icb_rsp_ready(i1_rsp_ready),
        .i1_icb_rsp_err(rr_i1_err), .i1_icb_rsp_rdata(rr_i1_rd),
        .o_icb_cmd_valid(rr_ov), .o_icb_cmd_ready(o_cmd_ready), .o_icb_cmd_addr(rr_addr),
        .o_icb_cmd_read(rr_read), .o_icb_cmd_wdata(rr_wdata), .o_icb_cmd_wmask(rr_wmask),
        .o_icb_cmd_size(rr_size), .o_icb_cmd_lock(rr_lock),
        .o_icb_rsp_valid(o_rsp_valid), .o_icb_rsp_ready(rr_ordy),
        .o_icb_rsp_err(1'b0), .o_icb_rsp_rdata(o_rsp_rdata)
    );

    sirv_icb2to1_arb #(.AW(32), .DW(32), .OUTS_NUM(2), .RR_EN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .i0_icb_cmd_valid(i0_valid), .i0_icb_cmd_ready(fp_i0_rdy), .i0_icb_cmd_addr(i0_addr),
        .i0_icb_cmd_read(1'b1), .i0_icb_cmd_wdata(32'h0), .i0_icb_cmd_wmask(4'hF),
        .i0_icb_cmd_size(2'd2), .i0_icb_cmd_lock(i0_lock),
        .i0_icb_rsp_valid(fp_i0_rv), .i0_icb_rsp_ready(i0_rsp_ready),
        .i0_icb_rsp_err(fp_i0_err), .i0_icb_rsp_rdata(fp_i0_rd),
        .i1_icb_cmd_valid(i1_valid), .i1_icb_cmd_ready(fp_i1_rdy), .i1_icb_cmd_addr(i1_addr),
        .i1_icb_cmd_read(1'b1), .i1_icb_cmd_wdata(32'h0), .i1_icb_cmd_wmask(4'hF),
        .i1_icb_cmd_size(2'd2), .i1_icb_cmd_lock(i1_lock),
        .i1_icb_rsp_valid(fp_i1_rv), .i1_icb_rsp_ready(i1_rsp_ready),
        .i1_icb_rsp_err(fp_i1_err), .i1_icb_rsp_rdata(fp_i1_rd),
        .o_icb_cmd_valid(fp_ov), .o_icb_cmd_ready(o_cmd_ready), .o_icb_cmd_addr(fp_addr),
        .o_icb_cmd_read(fp_read), .o_icb_cmd_wdata(fp_wdata), .o_icb_cmd_wmask(fp_wmask),
        .o_icb_cmd_size(fp_size), .o_icb_cmd_lock(fp_lock),
        .o_icb_rsp_valid(o_rsp_valid), .o_icb_rsp_ready(fp_ordy),
        .o_icb_rsp_err(1'b0), .o_icb_rsp_rdata(o_rsp_rdata)
    );

    // One-cycle slave: echoes the accepted address as read data on the next cycle
    always @(posedge clk) begin
        s_vld_q   <= auto_rsp & (sel_fp ? fp_ov : rr_ov) & o_cmd_ready;
        s_rdata_q <= sel_fp ? fp_addr : rr_addr;
    end
    assign o_rsp_valid = auto_rsp ? s_vld_q   : man_rsp_valid;
    assign o_rsp_rdata = auto_rsp ? s_rdata_q : man_rdata;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        i0_lock  = 1'b0;
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        logic g, p;

        // Reset: handshake outputs low even with requests and a stray response present
        #1 rst_n = 1'b0;
        i0_valid = 1'b1; i0_addr = 32'h100; man_rsp_valid = 1'b1;
        mid();
        chk1("rst_cmd_valid", rr_ov, 1'b0);
        chk1("rst_i0_ready", rr_i0_rdy, 1'b0);
        chk1("rst_rsp_ready", rr_ordy, 1'b0);
        chk1("rst_i0_rsp_valid", rr_i0_rv, 1'b0);

        // Round-robin, both masters always requesting, one-cycle slave
        nxt();
        rst_n = 1'b1; man_rsp_valid = 1'b0; o_cmd_ready = 1'b1; auto_rsp = 1'b1;
        i1_valid = 1'b1; i1_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            p = ~g;
            mid();
            chk32("rr_addr", rr_addr, g ? 32'h200 : 32'h100);
            chk1("rr_i0_ready", rr_i0_rdy, ~g);
            chk1("rr_i1_ready", rr_i1_rdy, g);
            if (k > 0) begin
                chk1("rr_i0_rsp_valid", rr_i0_rv, ~p);
                chk1("rr_i1_rsp_valid", rr_i1_rv, p);
                chk32("rr_rsp_rdata", rr_i0_rd, p ? 32'h200 : 32'h100);
            end
            nxt();
        end
        i0_valid = 1'b0; i1_valid = 1'b0;
        mid();
        chk1("rr_last_rsp_i1", rr_i1_rv, 1'b1);
        chk32("rr_last_rdata", rr_i1_rd, 32'h200);
        chk1("rr_idle_valid", rr_ov, 1'b0);
        nxt();

        // Fixed priority: i0 wins every cycle while valid
        sel_fp = 1'b1;
        do_reset();
        i0_valid = 1'b1; i1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk1("fp_i0_ready", fp_i0_rdy, 1'b1);
            chk1("fp_i1_ready", fp_i1_rdy, 1'b0);
            chk32("fp_addr", fp_addr, 32'h100);
            if (k > 0) chk1("fp_i0_rsp_valid", fp_i0_rv, 1'b1);
            nxt();
        end
        i0_valid = 1'b0;
        mid();
        chk1("fp_i1_ready_after", fp_i1_rdy, 1'b1);
        chk32("fp_addr_i1", fp_addr, 32'h200);
        chk1("fp_i0_rsp_last", fp_i0_rv, 1'b1);
        nxt();
        i1_valid = 1'b0;
        mid();
        chk1("fp_i1_rsp", fp_i1_rv, 1'b1);
        nxt();

        // Grant hold under back-pressure
        sel_fp = 1'b0;
        do_reset();
        o_cmd_ready = 1'b0; i1_valid = 1'b1; i1_addr = 32'h1000;
        mid();
        chk1("hold_valid", rr_ov, 1'b1);
        chk32("hold_addr0", rr_addr, 32'h1000);
        chk1("hold_i1_ready0", rr_i1_rdy, 1'b0);
        nxt();
        i0_valid = 1'b1; i0_addr = 32'h100;
        mid();
        chk32("hold_addr1", rr_addr, 32'h1000);
        chk1("hold_i0_ready1", rr_i0_rdy, 1'b0);
        nxt();
        mid();
        chk32("hold_addr2", rr_addr, 32'h1000);
        nxt();
        o_cmd_ready = 1'b1;
        mid();
        chk1("hold_i1_hs", rr_i1_rdy, 1'b1);
        chk1("hold_i0_blocked", rr_i0_rdy, 1'b0);
        chk32("hold_addr3", rr_addr, 32'h1000);
        nxt();
        i1_valid = 1'b0;
        mid();
        chk1("hold_i0_next", rr_i0_rdy, 1'b1);
        chk32("hold_addr_i0", rr_addr, 32'h100);
        chk1("hold_i1_rsp", rr_i1_rv, 1'b1);
        chk32("hold_i1_rdata", rr_i1_rd, 32'h1000);
        nxt();
        i0_valid = 1'b0;
        mid();
        chk1("hold_i0_rsp", rr_i0_rv, 1'b1);
        chk32("hold_i0_rdata", rr_i0_rd, 32'h100);
        nxt();

        // Lock sequence starves i1 until the unlocking handshake
        do_reset();
        i0_valid = 1'b1; i0_addr = 32'h2000; i0_lock = 1'b1;
        i1_valid = 1'b1; i1_addr = 32'h200;
        mid();
        chk32("lock_addr", rr_addr, 32'h2000);
        chk1("lock_flag", rr_lock, 1'b1);
        chk1("lock_i0_ready", rr_i0_rdy, 1'b1);
        nxt();
        i0_valid = 1'b0;
        mid();
        chk1("lock_i1_starved", rr_i1_rdy, 1'b0);
        chk1("lock_no_valid", rr_ov, 1'b0);
        chk1("lock_rsp_i0", rr_i0_rv, 1'b1);
        nxt();
        i0_valid = 1'b1; i0_addr = 32'h2004; i0_lock = 1'b0;
        mid();
        chk1("unlock_i1_starved", rr_i1_rdy, 1'b0);
        chk1("unlock_i0_ready", rr_i0_rdy, 1'b1);
        chk32("unlock_addr", rr_addr, 32'h2004);
        nxt();
        i0_valid = 1'b0;
        mid();
        chk1("post_lock_i1_ready", rr_i1_rdy, 1'b1);
        chk32("post_lock_addr", rr_addr, 32'h200);
        chk1("post_lock_rsp_i0", rr_i0_rv, 1'b1);
        nxt();
        i1_valid = 1'b0;
        nxt();

        // Outstanding limit, response routing, and reset with two commands in flight
        do_reset();
        auto_rsp = 1'b0; man_rsp_valid = 1'b0; man_rdata = 32'hAA;
        i0_valid = 1'b1; i0_addr = 32'h100; i1_valid = 1'b1; i1_addr = 32'h200;
        mid();
        chk1("full_i0_hs", rr_i0_rdy, 1'b1);
        nxt();
        mid();
        chk1("full_i1_hs", rr_i1_rdy, 1'b1);
        nxt();
        mid();
        chk1("full_valid", rr_ov, 1'b0);
        chk1("full_i0_ready", rr_i0_rdy, 1'b0);
        chk1("full_i1_ready", rr_i1_rdy, 1'b0);
        nxt();
        man_rsp_valid = 1'b1;
        mid();
        chk1("pop_i0_rsp", rr_i0_rv, 1'b1);
        chk1("pop_i1_rsp", rr_i1_rv, 1'b0);
        chk1("pop_rsp_ready", rr_ordy, 1'b1);
        chk1("pop_still_full", rr_ov, 1'b0);
        chk32("pop_rdata", rr_i0_rd, 32'hAA);
        nxt();
        man_rsp_valid = 1'b0;
        mid();
        chk1("refill_valid", rr_ov, 1'b1);
        chk1("refill_i0_ready", rr_i0_rdy, 1'b1);
        nxt();
        man_rsp_valid = 1'b1; i1_rsp_ready = 1'b0;
        mid();
        chk1("refull_valid", rr_ov, 1'b0);
        chk1("head_i1_rsp", rr_i1_rv, 1'b1);
        chk1("head_i0_rsp", rr_i0_rv, 1'b0);
        chk1("head_backpressure", rr_ordy, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rst_rsp", rr_i1_rv, 1'b0);
        chk1("async_rst_valid", rr_ov, 1'b0);
        chk1("async_rst_rsp_ready", rr_ordy, 1'b0);
        chk1("async_rst_i0_ready", rr_i0_rdy, 1'b0);
        nxt();
        rst_n = 1'b1; i1_rsp_ready = 1'b1;
        mid();
        chk1("stale_i0_rsp", rr_i0_rv, 1'b0);
        chk1("stale_i1_rsp", rr_i1_rv, 1'b0);
        chk1("stale_rsp_ready", rr_ordy, 1'b0);
        chk1("post_rst_valid", rr_ov, 1'b1);
        chk1("post_rst_i0_gnt", rr_i0_rdy, 1'b1);
        chk32("post_rst_addr", rr_addr, 32'h100);
        nxt();
        i0_valid = 1'b0; i1_valid = 1'b0; man_rsp_valid = 1'b0;
        nxt();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
